// File: rtl/mem_stage_pkg.sv
// Shared widths, RV64 load/store funct3 codes, FSM encoding and the completion record for mem_stage.
package mem_stage_pkg;
  localparam int BUS_64   = 64;
  localparam int BUS_RIDX = 5;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef struct packed {
    logic [BUS_RIDX-1:0] rd;
    logic                rd_wen;
    logic [BUS_64-1:0]   wdata;
    logic                misalign;
    logic                timeout;
  } wb_t;

  // Access size comes from funct3[1:0]; the offset must be a multiple of it.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [2:0] offset);
    case (funct3[1:0])
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = offset[0];
      2'b10:   is_misaligned = |offset[1:0];
      default: is_misaligned = |offset;
    endcase
  endfunction
endpackage

// File: rtl/mem_stage_align.sv
// Combinational lane logic: store strobe/data shift and load extract with sign/zero extension.
module mem_stage_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]        i_funct3,
  input  logic [2:0]        i_offset,
  input  logic [BUS_64-1:0] i_store_data,
  input  logic [BUS_64-1:0] i_rdata,
  output logic [7:0]        o_wstrb,
  output logic [BUS_64-1:0] o_wdata,
  output logic [BUS_64-1:0] o_load_data
);
  logic [5:0]        w_shamt;
  logic [7:0]        w_strb_base;
  logic [BUS_64-1:0] w_shifted;

  assign w_shamt   = {i_offset, 3'b000};
  assign w_shifted = i_rdata >> w_shamt;
  assign o_wdata   = i_store_data << w_shamt;
  assign o_wstrb   = w_strb_base << i_offset;

  always_comb begin
    case (i_funct3[1:0])
      2'b00:   w_strb_base = 8'h01;
      2'b01:   w_strb_base = 8'h03;
      2'b10:   w_strb_base = 8'h0F;
      default: w_strb_base = 8'hFF;
    endcase
  end

  // LD and the unused 3'b111 code both take the full word.
  always_comb begin
    case (i_funct3)
      F3_B:    o_load_data = {{56{w_shifted[7]}},  w_shifted[7:0]};
      F3_H:    o_load_data = {{48{w_shifted[15]}}, w_shifted[15:0]};
      F3_W:    o_load_data = {{32{w_shifted[31]}}, w_shifted[31:0]};
      F3_BU:   o_load_data = {56'd0, w_shifted[7:0]};
      F3_HU:   o_load_data = {48'd0, w_shifted[15:0]};
      F3_WU:   o_load_data = {32'd0, w_shifted[31:0]};
      default: o_load_data = w_shifted;
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// Memory-access stage between EX and WB: one load/store beat per instruction, ALU ops pass through.
// Optional MEM_STAGE_DIFFTEST_SKIP_EN adds o_skip, flagging memory ops outside [RAM_BASE, RAM_BASE+RAM_SIZE).
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int                TIMEOUT_CYCLES = 255,
  parameter logic [BUS_64-1:0] RAM_BASE       = 64'h8000_0000,
  parameter logic [BUS_64-1:0] RAM_SIZE       = 64'h0800_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_ena,
  output logic                o_ready,
  input  logic [BUS_RIDX-1:0] i_rd,
  input  logic                i_rd_wen,
  input  logic [BUS_64-1:0]   i_alu_result,
  input  logic                i_mem_ren,
  input  logic                i_mem_wen,
  input  logic [2:0]          i_funct3,
  input  logic [BUS_64-1:0]   i_store_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [BUS_64-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [BUS_64-1:0]   mem_req_wdata,
  output logic [7:0]          mem_req_wstrb,
  input  logic                mem_resp_valid,
  input  logic [BUS_64-1:0]   mem_resp_rdata,
  output logic                o_ena,
  output logic [BUS_RIDX-1:0] o_rd,
  output logic                o_rd_wen,
  output logic [BUS_64-1:0]   o_rd_wdata,
  output logic                o_exc_misalign,
`ifdef MEM_STAGE_DIFFTEST_SKIP_EN
  output logic                o_skip,
`endif
  output logic                o_exc_timeout
);
  logic [1:0]          r_state, w_state_n;
  logic [15:0]         r_cnt;
  logic                r_ena;
  wb_t                 r_wb, w_wb_n;
  logic [BUS_RIDX-1:0] r_rd;
  logic                r_rd_wen, r_load, r_req_wen;
  logic [2:0]          r_funct3, r_offset;
  logic [BUS_64-1:0]   r_addr, r_wdata;
  logic [7:0]          r_wstrb;

  logic                w_accept, w_is_mem, w_is_store, w_misalign, w_expire, w_in_wait;
  logic                w_done, w_start;
  logic [2:0]          w_funct3, w_offset;
  logic [7:0]          w_wstrb;
  logic [BUS_64-1:0]   w_wdata, w_load_data;

  assign o_ready    = (r_state == ST_IDLE) | (r_state == ST_DONE);
  assign w_accept   = i_ena & o_ready;
  assign w_is_mem   = i_mem_ren | i_mem_wen;
  assign w_is_store = i_mem_wen & ~i_mem_ren;
  assign w_misalign = is_misaligned(i_funct3, i_alu_result[2:0]);
  assign w_expire   = (r_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign w_in_wait  = (r_state == ST_WAIT);

  // The aligner serves the store path at accept time and the load path in WAIT.
  assign w_funct3 = w_in_wait ? r_funct3 : i_funct3;
  assign w_offset = w_in_wait ? r_offset : i_alu_result[2:0];

  mem_stage_align u_align (
    .i_funct3     (w_funct3),
    .i_offset     (w_offset),
    .i_store_data (i_store_data),
    .i_rdata      (mem_resp_rdata),
    .o_wstrb      (w_wstrb),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data)
  );

  always_comb begin
    w_state_n = r_state;
    w_done    = 1'b0;
    w_start   = 1'b0;
    w_wb_n    = '{rd: r_rd, rd_wen: 1'b0, wdata: '0, misalign: 1'b0, timeout: 1'b0};
    case (r_state)
      ST_REQ: begin
        if (w_expire) begin
          w_done         = 1'b1;
          w_wb_n.timeout = 1'b1;
        end else if (mem_req_ready) begin
          w_state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A response in the expiry cycle still completes the access.
        if (mem_resp_valid) begin
          w_done        = 1'b1;
          w_wb_n.rd_wen = r_rd_wen;
          w_wb_n.wdata  = r_load ? w_load_data : '0;
        end else if (w_expire) begin
          w_done         = 1'b1;
          w_wb_n.timeout = 1'b1;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        if (w_accept) begin
          if (!w_is_mem) begin
            w_done = 1'b1;
            w_wb_n = '{rd: i_rd, rd_wen: i_rd_wen & (|i_rd), wdata: i_alu_result,
                       misalign: 1'b0, timeout: 1'b0};
          end else if (w_misalign) begin
            w_done          = 1'b1;
            w_wb_n.rd       = i_rd;
            w_wb_n.misalign = 1'b1;
          end else begin
            w_start   = 1'b1;
            w_state_n = ST_REQ;
          end
        end
      end
    endcase
    if (w_done) w_state_n = ST_DONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_ena     <= 1'b0;
      r_wb      <= '0;
      r_rd      <= '0;
      r_rd_wen  <= 1'b0;
      r_load    <= 1'b0;
      r_funct3  <= '0;
      r_offset  <= '0;
      r_addr    <= '0;
      r_req_wen <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      r_state <= w_state_n;
      r_ena   <= w_done;
      if (w_done) r_wb <= w_wb_n;
      if (w_start) begin
        r_cnt     <= '0;
        r_rd      <= i_rd;
        r_rd_wen  <= i_rd_wen & (|i_rd) & ~w_is_store;
        r_load    <= i_mem_ren;
        r_funct3  <= i_funct3;
        r_offset  <= i_alu_result[2:0];
        r_addr    <= {i_alu_result[BUS_64-1:3], 3'b000};
        r_req_wen <= w_is_store;
        r_wdata   <= w_is_store ? w_wdata : '0;
        r_wstrb   <= w_is_store ? w_wstrb : '0;
      end else if ((r_state == ST_REQ) || w_in_wait) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

`ifdef MEM_STAGE_DIFFTEST_SKIP_EN
  logic w_mmio, r_skip_pend;
  assign w_mmio = (i_alu_result < RAM_BASE) | (i_alu_result >= RAM_BASE + RAM_SIZE);

  // Completions straight from accept are ALU ops (never skipped) or misaligned memory ops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_skip_pend <= 1'b0;
      o_skip      <= 1'b0;
    end else begin
      if (w_start) r_skip_pend <= w_mmio;
      if (w_done)  o_skip <= o_ready ? (w_is_mem & w_mmio) : r_skip_pend;
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{RAM_BASE, RAM_SIZE};
`endif

  assign mem_req_valid  = (r_state == ST_REQ);
  assign mem_req_addr   = r_addr;
  assign mem_req_wen    = r_req_wen;
  assign mem_req_wdata  = r_wdata;
  assign mem_req_wstrb  = r_wstrb;
  assign o_ena          = r_ena;
  assign o_rd           = r_wb.rd;
  assign o_rd_wen       = r_wb.rd_wen;
  assign o_rd_wdata     = r_wb.wdata;
  assign o_exc_misalign = r_wb.misalign;
  assign o_exc_timeout  = r_wb.timeout;
endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: bench-side memory slave, arithmetic reference model, per-cycle compare.
module tb_mem_stage;
  localparam int T = 255;

  logic        clk = 1'b0, rst = 1'b0;
  logic        i_ena = 1'b0, i_rd_wen = 1'b0, i_mem_ren = 1'b0, i_mem_wen = 1'b0;
  logic [4:0]  i_rd = '0;
  logic [63:0] i_alu_result = '0, i_store_data = '0, mem_resp_rdata = '0;
  logic [2:0]  i_funct3 = '0;
  logic        mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
  logic        o_ready, mem_req_valid, mem_req_wen, o_ena, o_rd_wen, o_exc_misalign, o_exc_timeout;
  logic [63:0] mem_req_addr, mem_req_wdata, o_rd_wdata;
  logic [7:0]  mem_req_wstrb;
  logic [4:0]  o_rd;
`ifdef MEM_STAGE_DIFFTEST_SKIP_EN
  logic        o_skip;
`endif

  mem_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .i_ena(i_ena), .o_ready(o_ready), .i_rd(i_rd), .i_rd_wen(i_rd_wen),
    .i_alu_result(i_alu_result), .i_mem_ren(i_mem_ren), .i_mem_wen(i_mem_wen),
    .i_funct3(i_funct3), .i_store_data(i_store_data), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata), .o_ena(o_ena), .o_rd(o_rd), .o_rd_wen(o_rd_wen),
    .o_rd_wdata(o_rd_wdata), .o_exc_misalign(o_exc_misalign),
`ifdef MEM_STAGE_DIFFTEST_SKIP_EN
    .o_skip(o_skip),
`endif
    .o_exc_timeout(o_exc_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] wdata;
    logic        chk;
    logic        mis;
    logic        tmo;
  } exp_t;

  exp_t        expq[$];
  exp_t        last, cur;
  int          cyc = 0, checks = 0, errors = 0;
  int          g_n = 0, g_ena_cyc = 0;
  logic [7:0]  g_wstrb;
  logic [63:0] g_wdata;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t reset_exp();
    exp_t e;
    e.cyc = 0; e.rd = '0; e.wen = 1'b0; e.wdata = '0; e.chk = 1'b1; e.mis = 1'b0; e.tmo = 1'b0;
    return e;
  endfunction

  // Reference: what writeback must see, and when, from the access rules alone.
  function automatic exp_t model(input int n, input logic [4:0] rd, input logic rdw,
                                 input logic [63:0] a, input logic ren, input logic wen,
                                 input logic [2:0] f3, input logic [63:0] rdata,
                                 input int rdy, input int rsp);
    exp_t e;
    int size, off, idx;
    logic [63:0] v, mask;
    e.cyc = n; e.rd = rd; e.wen = 1'b0; e.wdata = '0; e.chk = 1'b0; e.mis = 1'b0; e.tmo = 1'b0;
    size = 1 << f3[1:0];
    off  = int'(a[2:0]);
    if (!(ren || wen)) begin
      e.wen = rdw && (rd != 0); e.wdata = a; e.chk = 1'b1;
      return e;
    end
    if (off % size != 0) begin
      e.mis = 1'b1;
      return e;
    end
    idx = rdy + 1 + rsp;
    if (rdy >= T - 1 || idx > T - 1) begin
      e.tmo = 1'b1; e.cyc = n + T;
      return e;
    end
    e.cyc = n + idx + 1;
    if (ren) begin
      v    = rdata >> (8 * off);
      mask = (size == 8) ? '1 : ((64'd1 << (8 * size)) - 64'd1);
      v    = v & mask;
      if (!f3[2] && size < 8 && v[8*size-1]) v = v | ~mask;
      e.wdata = v; e.chk = 1'b1; e.wen = rdw && (rd != 0);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (o_ena) begin
        g_ena_cyc = cyc;
        if (expq.size() == 0) begin
          chk("unexpected_ena", 64'(o_ena), 64'd0);
        end else begin
          cur = expq.pop_front();
          chk("ena_cycle", 64'(cyc), 64'(cur.cyc));
          chk("o_rd", 64'(o_rd), 64'(cur.rd));
          chk("o_rd_wen", 64'(o_rd_wen), 64'(cur.wen));
          chk("o_exc_misalign", 64'(o_exc_misalign), 64'(cur.mis));
          chk("o_exc_timeout", 64'(o_exc_timeout), 64'(cur.tmo));
          if (cur.chk) chk("o_rd_wdata", o_rd_wdata, cur.wdata);
          last = cur;
        end
      end else begin
        chk("hold_rd", 64'(o_rd), 64'(last.rd));
        chk("hold_rd_wen", 64'(o_rd_wen), 64'(last.wen));
        chk("hold_flags", 64'({o_exc_misalign, o_exc_timeout}), 64'({last.mis, last.tmo}));
        if (last.chk) chk("hold_wdata", o_rd_wdata, last.wdata);
      end
    end
  end

  // Issue one instruction and act as the memory: ready after rdy REQ cycles, response rsp cycles later.
  task automatic run_op(input logic [4:0] rd, input logic rdw, input logic [63:0] a,
                        input logic ren, input logic wen, input logic [2:0] f3,
                        input logic [63:0] sd, input logic [63:0] rdata,
                        input int rdy, input int rsp, input bit linger);
    exp_t e;
    int n, rsp_idx, req_last, kend, sz, off, s;
    logic aligned, is_store;
    logic [7:0] xstrb;
    logic [63:0] xwdata;
    i_ena = 1'b1; i_rd = rd; i_rd_wen = rdw; i_alu_result = a; i_mem_ren = ren;
    i_mem_wen = wen; i_funct3 = f3; i_store_data = sd; mem_resp_rdata = rdata;
    chk("ready_at_issue", 64'(o_ready), 64'd1);
    tick();
    i_ena = 1'b0;
    n = cyc; g_n = n;
    e = model(n, rd, rdw, a, ren, wen, f3, rdata, rdy, rsp);
    expq.push_back(e);
    sz = 1 << f3[1:0]; off = int'(a[2:0]);
    s = ((1 << sz) - 1) << off;
    xstrb = s[7:0];
    xwdata = sd << (8 * off);
    is_store = wen && !ren;
    aligned = (ren || wen) && !e.mis;
    req_last = aligned ? ((rdy < T - 1) ? rdy : T - 1) : -1;
    rsp_idx = rdy + 1 + rsp;
    kend = e.cyc - n - 1;
    if (aligned && rsp_idx > kend) kend = rsp_idx;
    if (linger) kend = kend + 1;
    for (int k = 0; k <= kend; k++) begin
      mem_req_ready  = aligned && (k == rdy);
      mem_resp_valid = aligned && (k == rsp_idx);
      chk("req_valid", 64'(mem_req_valid), 64'(k <= req_last));
      if (k <= req_last) begin
        chk("req_addr", mem_req_addr, {a[63:3], 3'b000});
        chk("req_wen", 64'(mem_req_wen), 64'(is_store));
        if (is_store) begin
          chk("req_wstrb", 64'(mem_req_wstrb), 64'(xstrb));
          chk("req_wdata", mem_req_wdata, xwdata);
        end
        g_wstrb = mem_req_wstrb; g_wdata = mem_req_wdata;
      end
      tick();
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    if (linger) begin
      chk("completion_seen", 64'(expq.size()), 64'd0);
      expq.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    last = reset_exp();
    tick(); tick();
    chk("reset_ready", 64'(o_ready), 64'd1);
    chk("reset_req_valid", 64'(mem_req_valid), 64'd0);
    chk("reset_ena", 64'(o_ena), 64'd0);
    chk("reset_wdata", o_rd_wdata, 64'd0);
    chk("reset_wstrb", 64'(mem_req_wstrb), 64'd0);
    rst = 1'b1;
    tick();

    // Back-to-back ALU ops.
    run_op(5'd5, 1'b1, 64'h1234, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 0, 0, 1'b0);
    chk("alu1_ena", 64'(o_ena), 64'd1);
    chk("alu1_rd", 64'(o_rd), 64'd5);
    chk("alu1_wdata", o_rd_wdata, 64'h1234);
    run_op(5'd6, 1'b1, 64'h5678, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 0, 0, 1'b1);
    chk("alu2_latency", 64'(g_ena_cyc - g_n), 64'd0);
    chk("alu2_wdata", o_rd_wdata, 64'h5678);

    // LB / LBU with minimum memory latency.
    run_op(5'd7, 1'b1, 64'h8000_0003, 1'b1, 1'b0, 3'b000, 64'd0, 64'h0000_0000_8000_0000, 0, 0, 1'b1);
    chk("lb_wdata", o_rd_wdata, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_latency", 64'(g_ena_cyc - g_n), 64'd2);
    run_op(5'd7, 1'b1, 64'h8000_0003, 1'b1, 1'b0, 3'b100, 64'd0, 64'h0000_0000_8000_0000, 1, 2, 1'b1);
    chk("lbu_wdata", o_rd_wdata, 64'h80);

    // SH into the top half-word.
    run_op(5'd9, 1'b1, 64'h8000_0006, 1'b0, 1'b1, 3'b001, 64'hABCD, 64'd0, 0, 1, 1'b1);
    chk("sh_wstrb", 64'(g_wstrb), 64'hC0);
    chk("sh_wdata", g_wdata, 64'hABCD_0000_0000_0000);
    chk("sh_rd_wen", 64'(o_rd_wen), 64'd0);

    // Misaligned LW.
    run_op(5'd3, 1'b1, 64'h8000_0002, 1'b1, 1'b0, 3'b010, 64'd0, 64'd0, 0, 0, 1'b1);
    chk("lw_misalign", 64'(o_exc_misalign), 64'd1);

    // Timeout in REQ, late response ignored, then a normal load.
    run_op(5'd4, 1'b1, 64'h8000_0010, 1'b1, 1'b0, 3'b011, 64'd0, 64'h1111, 300, 2, 1'b1);
    chk("tmo_flag", 64'(o_exc_timeout), 64'd1);
    chk("tmo_latency", 64'(g_ena_cyc - g_n), 64'(T));
    run_op(5'd4, 1'b1, 64'h8000_0010, 1'b1, 1'b0, 3'b011, 64'd0, 64'hDEAD_BEEF_0123_4567, 0, 0, 1'b1);
    chk("after_tmo_wdata", o_rd_wdata, 64'hDEAD_BEEF_0123_4567);

    // Response in the expiry cycle wins; one cycle later it is a timeout.
    run_op(5'd8, 1'b1, 64'h8000_0020, 1'b1, 1'b0, 3'b010, 64'd0, 64'h7FFF_FFFF, 10, 243, 1'b1);
    chk("edge_resp_wins", 64'(o_exc_timeout), 64'd0);
    chk("edge_resp_wdata", o_rd_wdata, 64'h7FFF_FFFF);
    run_op(5'd8, 1'b1, 64'h8000_0020, 1'b1, 1'b0, 3'b010, 64'd0, 64'h7FFF_FFFF, 10, 244, 1'b1);
    chk("edge_timeout", 64'(o_exc_timeout), 64'd1);

    // Reset while waiting for a response.
    i_ena = 1'b1; i_rd = 5'd2; i_rd_wen = 1'b1; i_alu_result = 64'h8000_0008;
    i_mem_ren = 1'b1; i_mem_wen = 1'b0; i_funct3 = 3'b011;
    tick();
    i_ena = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_ena", 64'(o_ena), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_rd_wen", 64'(o_rd_wen), 64'd0);
    expq.delete();
    last = reset_exp();
    tick();
    rst = 1'b1;
    tick();
    run_op(5'd2, 1'b1, 64'h8000_0008, 1'b1, 1'b0, 3'b010, 64'd0, 64'h0000_0000_FFFF_FFFE, 0, 0, 1'b1);
    chk("post_rst_lw", o_rd_wdata, 64'hFFFF_FFFF_FFFF_FFFE);

    // Randomized mix.
    for (int i = 0; i < 300; i++) begin
      int kind;
      logic [2:0] f3;
      kind = $urandom_range(0, 3);
      f3 = 3'($urandom_range(0, 7));
      if (kind == 2) f3[2] = 1'b0;
      run_op(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             64'h8000_0000 + 64'($urandom_range(0, 255)),
             (kind == 1) || (kind == 3), kind >= 2, f3,
             {$urandom, $urandom}, {$urandom, $urandom},
             $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    tick(); tick();
    chk("final_drain", 64'(expq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
